// File: rtl/goal_det_pkg.sv
// Shared types and defaults for the break-beam goal detector.
package goal_det_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    QUAL,
    BLOCKED,
    STUCK
  } goal_state_t;

  // Defaults assume a 50 MHz clock: 10 ms debounce, 1 s lockout, 3 s stuck limit.
  localparam int unsigned GD_DEBOUNCE_DEF = 500000;
  localparam int unsigned GD_LOCKOUT_DEF  = 50000000;
  localparam int unsigned GD_STUCK_DEF    = 150000000;

  // Raw sensor level that means the beam is interrupted.
  localparam logic GD_BEAM_BLOCKED_LVL = 1'b0;

endpackage

// File: rtl/goal_detector_if.sv
// Sensor/enable inputs and scoring outputs of the goal detector.
// master: game-core side, slave: detector side.
interface goal_detector_if;
  logic GPIO_0;
  logic ENABLE;
  logic GOAL_PULSE;
  logic GOAL_REJECT;
  logic BEAM_BLOCKED;
  logic LOCKOUT;
  logic FAULT;

  modport master (
    output GPIO_0, ENABLE,
    input  GOAL_PULSE, GOAL_REJECT, BEAM_BLOCKED, LOCKOUT, FAULT
  );

  modport slave (
    input  GPIO_0, ENABLE,
    output GOAL_PULSE, GOAL_REJECT, BEAM_BLOCKED, LOCKOUT, FAULT
  );
endinterface

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser with a configurable reset level.
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input; synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/goal_detector.sv
// Break-beam goal detector: synchronise, debounce, qualify one goal per passage,
// enforce an inter-goal lockout. Define GOAL_STUCK_DETECT_EN to build the
// stuck-sensor detection (STUCK state and FAULT); otherwise FAULT is tied low.
module goal_detector
  import goal_det_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = GD_DEBOUNCE_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = GD_LOCKOUT_DEF,
  parameter int unsigned STUCK_CYCLES    = GD_STUCK_DEF
) (
  input logic            CLOCK_50,
  input logic            RESET,
  goal_detector_if.slave bus
);
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LkW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES);
  localparam logic [LkW-1:0] LkMax = LkW'(LOCKOUT_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || STUCK_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("goal_detector: need DEBOUNCE_CYCLES >= 1 and STUCK_CYCLES > DEBOUNCE_CYCLES");
  end

  logic sync_q;
  logic blk;

  goal_state_t    state_q, state_d;
  logic [DbW-1:0] dcnt_q, dcnt_d;
  logic [DbW-1:0] ccnt_q, ccnt_d;
  logic [LkW-1:0] lock_q, lock_d;
  logic           pulse_q, pulse_d;
  logic           reject_q, reject_d;
  logic           bb_q, bb_d;
`ifdef GOAL_STUCK_DETECT_EN
  localparam int unsigned StW = $clog2(STUCK_CYCLES + 1);
  localparam logic [StW-1:0] StMax = StW'(STUCK_CYCLES);
  logic [StW-1:0] scnt_q, scnt_d;
  logic           fault_q, fault_d;
`endif

  sync_2ff #(
    .ResetVal(~GD_BEAM_BLOCKED_LVL)
  ) u_sync (
    .clk_i(CLOCK_50),
    .rst_i(RESET),
    .d_i  (bus.GPIO_0),
    .q_o  (sync_q)
  );

  assign blk = (sync_q == GD_BEAM_BLOCKED_LVL);

  // Next-state: debounce FSM, goal evaluation, lockout countdown, stuck timer.
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    ccnt_d   = ccnt_q;
    lock_d   = (lock_q != '0) ? lock_q - LkW'(1) : lock_q;
    pulse_d  = 1'b0;
    reject_d = 1'b0;
`ifdef GOAL_STUCK_DETECT_EN
    scnt_d   = scnt_q;
`endif
    unique case (state_q)
      CLEAR: begin
        if (blk) begin
          state_d = QUAL;
          dcnt_d  = DbW'(1);
        end
      end
      QUAL: begin
        if (!blk) begin
          state_d = CLEAR;
          dcnt_d  = '0;
        end else if (dcnt_q == DbMax) begin
          state_d = BLOCKED;
          dcnt_d  = '0;
          ccnt_d  = '0;
`ifdef GOAL_STUCK_DETECT_EN
          scnt_d  = '0;
`endif
          // Registered lock count is used, so a residual count of 1 still rejects.
          if (bus.ENABLE && lock_q == '0) begin
            pulse_d = 1'b1;
            lock_d  = LkMax;
          end else begin
            reject_d = 1'b1;
          end
        end else if (dcnt_q < DbMax) begin
          dcnt_d = dcnt_q + DbW'(1);
        end
      end
      BLOCKED, STUCK: begin
        if (ccnt_q == DbMax) begin
          state_d = CLEAR;
          ccnt_d  = '0;
        end else begin
          if (blk) begin
            ccnt_d = '0;
          end else begin
            ccnt_d = ccnt_q + DbW'(1);
          end
`ifdef GOAL_STUCK_DETECT_EN
          if (state_q == BLOCKED) begin
            if (scnt_q < StMax) begin
              scnt_d = scnt_q + StW'(1);
            end
            if (scnt_d == StMax) begin
              state_d = STUCK;
            end
          end
`endif
        end
      end
    endcase
    bb_d = (state_d == BLOCKED) || (state_d == STUCK);
`ifdef GOAL_STUCK_DETECT_EN
    fault_d = (state_d == STUCK);
`endif
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q  <= CLEAR;
      dcnt_q   <= '0;
      ccnt_q   <= '0;
      lock_q   <= '0;
      pulse_q  <= 1'b0;
      reject_q <= 1'b0;
      bb_q     <= 1'b0;
`ifdef GOAL_STUCK_DETECT_EN
      scnt_q   <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      ccnt_q   <= ccnt_d;
      lock_q   <= lock_d;
      pulse_q  <= pulse_d;
      reject_q <= reject_d;
      bb_q     <= bb_d;
`ifdef GOAL_STUCK_DETECT_EN
      scnt_q   <= scnt_d;
      fault_q  <= fault_d;
`endif
    end
  end

  assign bus.GOAL_PULSE   = pulse_q;
  assign bus.GOAL_REJECT  = reject_q;
  assign bus.BEAM_BLOCKED = bb_q;
  assign bus.LOCKOUT      = (lock_q != '0);
`ifdef GOAL_STUCK_DETECT_EN
  assign bus.FAULT        = fault_q;
`else
  assign bus.FAULT        = 1'b0;
`endif
endmodule
